// File: rtl/dadda_mac_acc.sv
// Unsigned 16x16 multiply-accumulate over in_last-delimited frames.
// Operand register -> product register -> accumulator/result register.

// Combinational 16x16 unsigned multiplier: partial products are folded
// through a carry-save adder chain, then resolved by one carry-propagate add.
module dadda (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out
);
  logic [31:0] w_s;
  logic [31:0] w_c;
  logic [31:0] w_pp;
  logic [31:0] w_ns;
  logic [31:0] w_nc;
  logic [15:0] w_bsh;

  // Reduce the sixteen shifted partial products to a sum/carry pair.
  always_comb begin
    w_s   = {16'b0, a & {16{b[0]}}};
    w_c   = {15'b0, a & {16{b[1]}}, 1'b0};
    w_pp  = '0;
    w_ns  = '0;
    w_nc  = '0;
    w_bsh = '0;
    for (int i = 2; i < 16; i++) begin
      w_bsh = b >> i;
      w_pp  = {16'b0, a & {16{w_bsh[0]}}} << i;
      w_ns  = w_s ^ w_c ^ w_pp;
      w_nc  = ((w_s & w_c) | (w_s & w_pp) | (w_c & w_pp)) << 1;
      w_s   = w_ns;
      w_c   = w_nc;
    end
  end

  // Product is below 2^32, so dropping carries past bit 31 is exact.
  assign out = w_s + w_c;
endmodule

module dadda_mac_acc #(
  parameter int ACC_W    = 40,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  logic [15:0]      r_a_p1;
  logic [15:0]      r_b_p1;
  logic             r_vld_p1;
  logic             r_last_p1;
  logic [ACC_W-1:0] r_prod_p2;
  logic             r_vld_p2;
  logic             r_last_p2;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [31:0]      w_prod;
  logic             w_accept;
  logic [ACC_W:0]   w_nsum;
  logic             w_ovf_nxt;
  logic [ACC_W-1:0] w_res;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Clamp to all-ones once the frame has overflowed, else keep the low bits.
  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] nsum,
                                               input logic ovf);
    if ((SATURATE != 0) && ovf) return '1;
    return nsum[ACC_W-1:0];
  endfunction

  // Term counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // Stall while a last term is in flight or the held result is unread.
  assign in_ready = !rst && !(r_vld_p1 && r_last_p1) && !(r_vld_p2 && r_last_p2)
                    && !(out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;

  dadda u_mul (.a(r_a_p1), .b(r_b_p1), .out(w_prod));

  assign w_nsum    = {1'b0, r_acc} + {1'b0, r_prod_p2};
  assign w_ovf_nxt = r_ovf | w_nsum[ACC_W];
  assign w_res     = sat_sum(w_nsum, w_ovf_nxt);
  assign w_cnt_nxt = cnt_inc(r_cnt);

  // Data path registers: operands captured on accept, product every cycle.
  always_ff @(posedge clk) begin
    // p1: operand capture
    if (w_accept) begin
      r_a_p1 <= in_a;
      r_b_p1 <= in_b;
    end
    // p2: registered product
    r_prod_p2 <= ACC_W'(w_prod);
  end

  // Control, accumulator and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // p1: accept flags
      r_vld_p1  <= w_accept;
      r_last_p1 <= w_accept && in_last;
      // p2: follow the operand stage
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      // accumulate / emit
      if (r_vld_p2 && r_last_p2) begin
        out_sum   <= w_res;
        out_count <= w_cnt_nxt;
        out_ovf   <= w_ovf_nxt;
        out_valid <= 1'b1;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        if (r_vld_p2) begin
          r_acc <= w_res;
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
        end
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dadda_mac_acc.sv
module tb_dadda_mac_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic        s_in_ready, s_valid, s_ovf;
  logic [31:0] s_sum;
  logic [7:0]  s_count;
  logic        w_in_ready, w_valid, w_ovf;
  logic [31:0] w_sum;
  logic [7:0]  w_count;

  int checks = 0;
  int errors = 0;

  dadda_mac_acc #(.ACC_W(40), .CNT_W(8), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf));

  dadda_mac_acc #(.ACC_W(32), .CNT_W(8), .SATURATE(1)) dut_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_valid),
    .out_ready(out_ready), .out_sum(s_sum), .out_count(s_count), .out_ovf(s_ovf));

  dadda_mac_acc #(.ACC_W(32), .CNT_W(8), .SATURATE(0)) dut_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(w_valid),
    .out_ready(out_ready), .out_sum(w_sum), .out_count(w_count), .out_ovf(w_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present a pair at the next falling edge and hold it until in_ready.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("send_ready", in_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clears", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q_sum[$];
    int          q_cnt[$];
    logic [63:0] fsum;
    int          fcnt, terms_left, frames_sent, cyc;
    logic        have_pair, seen;
    logic [15:0] pa, pb;
    logic        plast;
    localparam int NF = 300;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single-term frame with exact latency
    send(16'd3, 16'd5, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    chk("t1_lat_e0", out_valid, 0);
    @(negedge clk);
    chk("t1_lat_e1", out_valid, 0);
    @(negedge clk);
    chk("t1_lat_e2", out_valid, 1);
    chk("t1_sum", out_sum, 15);
    chk("t1_count", out_count, 1);
    chk("t1_ovf", out_ovf, 0);
    consume();

    // Four back-to-back full-scale terms
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_last = (k == 3);
      #1;
      chk("t2_in_ready", in_ready, 1);
      chk("t2_s32_in_ready", s_in_ready, 1);
    end
    idle(1);
    wait_out();
    chk("t2_sum", out_sum, 64'h3_FFF8_0004);
    chk("t2_count", out_count, 4);
    chk("t2_ovf", out_ovf, 0);
    consume();

    // 32-bit overflow: saturating and wrapping variants
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    idle(1);
    wait_out();
    chk("t3_w40_sum", out_sum, 64'h1_FFFC_0002);
    chk("t3_w40_ovf", out_ovf, 0);
    chk("t3_sat_valid", s_valid, 1);
    chk("t3_sat_sum", s_sum, 64'hFFFF_FFFF);
    chk("t3_sat_ovf", s_ovf, 1);
    chk("t3_sat_count", s_count, 2);
    chk("t3_wrap_valid", w_valid, 1);
    chk("t3_wrap_sum", w_sum, 64'hFFFC_0002);
    chk("t3_wrap_ovf", w_ovf, 1);
    chk("t3_wrap_count", w_count, 2);
    chk("t3_wrap_in_ready", w_in_ready, 0);
    consume();

    // Backpressure holds the result and blocks the next frame
    send(16'd2, 16'd2, 1'b1);
    idle(1);
    wait_out();
    chk("t4_f1_sum", out_sum, 4);
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd10; in_b = 16'd10; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_sum", out_sum, 4);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("t4_f1_consumed", out_valid, 0);
    wait_out();
    chk("t4_f2_sum", out_sum, 100);
    chk("t4_f2_count", out_count, 1);
    consume();

    // Reset mid-frame discards partial work
    send(16'd3, 16'd3, 1'b0);
    send(16'd4, 16'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    chk("t5_rst_count", out_count, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); seen = seen | out_valid;
    end
    chk("t5_no_result", seen, 0);
    send(16'd2, 16'd7, 1'b1);
    idle(1);
    wait_out();
    chk("t5_sum", out_sum, 14);
    chk("t5_count", out_count, 1);
    consume();

    // Zero operand and a bubble inside a frame
    send(16'd0, 16'h1234, 1'b1);
    idle(1);
    wait_out();
    chk("zero_sum", out_sum, 0);
    chk("zero_count", out_count, 1);
    consume();
    send(16'd1, 16'd2, 1'b0);
    idle(3);
    send(16'd3, 16'd4, 1'b1);
    idle(1);
    wait_out();
    chk("bubble_sum", out_sum, 14);
    chk("bubble_count", out_count, 2);
    consume();

    // Random frames with valid and ready gaps against a running model
    fsum = '0; fcnt = 0; terms_left = 0; frames_sent = 0; cyc = 0;
    have_pair = 1'b0; pa = '0; pb = '0; plast = 1'b0;
    while ((frames_sent < NF || q_sum.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have_pair && frames_sent < NF && $urandom_range(0, 3) != 0) begin
        if (terms_left == 0) terms_left = $urandom_range(1, 16);
        pa = 16'($urandom); pb = 16'($urandom);
        plast = (terms_left == 1);
        have_pair = 1'b1;
      end
      in_valid = have_pair; in_a = pa; in_b = pb; in_last = plast;
      #1;
      if (out_valid && out_ready) begin
        if (q_sum.size() == 0) begin
          chk("rand_extra_result", 1, 0);
        end else begin
          chk("rand_sum", out_sum, q_sum.pop_front());
          chk("rand_count", out_count, q_cnt.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        fsum = fsum + 64'(pa) * 64'(pb);
        fcnt++;
        terms_left--;
        have_pair = 1'b0;
        if (plast) begin
          q_sum.push_back(fsum);
          q_cnt.push_back(fcnt);
          fsum = '0; fcnt = 0;
          frames_sent++;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("rand_frames_sent", frames_sent, NF);
    chk("rand_queue_empty", q_sum.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
